// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file write scheduler.
package regfile_pkg;

   localparam int REG_DEPTH = 32;
   localparam int REG_BITS  = 64;
   localparam int REG_AW    = $clog2(REG_DEPTH);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   typedef struct packed {
      logic                valid;
      logic [REG_AW-1:0]   addr;
      logic [REG_BITS-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bundle of writeback, load-return, register-file and status signals around the scheduler.
interface regfile_write_scheduler_if
   import regfile_pkg::*;
#(
   parameter int DEPTH = REG_DEPTH,
   parameter int BITS  = REG_BITS
);
   localparam int AW = $clog2(DEPTH);

   logic             wb_valid;
   logic [AW-1:0]    wb_addr;
   logic [BITS-1:0]  wb_data;
   logic             ld_valid;
   logic             ld_ready;
   logic [AW-1:0]    ld_addr;
   logic [BITS-1:0]  ld_data;
   logic [AW-1:0]    rf_addressw;
   logic [BITS-1:0]  rf_writeData;
   logic             rf_writeEn;
   logic             busy;
   logic [DEPTH-1:0] pending_mask;

   modport master (
      output wb_valid, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
      input  ld_ready, rf_addressw, rf_writeData, rf_writeEn, busy, pending_mask
   );

   modport slave (
      input  wb_valid, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
      output ld_ready, rf_addressw, rf_writeData, rf_writeEn, busy, pending_mask
   );
endinterface

// File: rtl/regfile_write_scheduler_hot_bit.sv
// One-hot decoder: sets bit idx of hot when en is high, otherwise all zero.
module Hot_Bit #(
   parameter int N  = 32,
   parameter int AW = $clog2(N)
) (
   input  logic [AW-1:0] idx,
   input  logic          en,
   output logic [N-1:0]  hot
);
   always_comb begin
      hot = '0;
      if (en) hot[idx] = 1'b1;
   end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register file write port: post-reset clear sweep, then writeback/load arbitration
// with a single-entry load holding buffer.
//
//   state | meaning
//   CLEAR | writing zero to r1..r(DEPTH-1), one per cycle; loads refused, busy high
//   RUN   | writeback > buffered load > direct load on the single write port
module regfile_write_scheduler
   import regfile_pkg::*;
#(
   parameter int DEPTH = REG_DEPTH,
   parameter int BITS  = REG_BITS
) (
   input logic                      clk,
   input logic                      rst,
   regfile_write_scheduler_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_idx_q, clr_idx_d;
   wr_req_t         buf_q, buf_d;
   logic [AW-1:0]   last_addr_q, last_addr_d;
   logic [BITS-1:0] last_data_q, last_data_d;

   wr_req_t port_req;
   logic    ld_ready;
   logic    wb_hit;
   logic    ld_take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= CLEAR;
         clr_idx_q   <= AW'(1);
         buf_q       <= '0;
         last_addr_q <= '0;
         last_data_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_idx_q   <= clr_idx_d;
         buf_q       <= buf_d;
         last_addr_q <= last_addr_d;
         last_data_q <= last_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (clr_idx_q == LAST_IDX) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end

   // Request qualification only looks at registered state, so ld_ready has no input path.
   assign ld_ready = (state_q == RUN) && !buf_q.valid;
   assign wb_hit   = (state_q == RUN) && bus.wb_valid && (bus.wb_addr != '0);
   assign ld_take  = ld_ready && bus.ld_valid && (bus.ld_addr != '0);

   always_comb begin
      port_req.valid = 1'b0;
      port_req.addr  = last_addr_q;
      port_req.data  = last_data_q;
      if (state_q == CLEAR) begin
         port_req.valid = 1'b1;
         port_req.addr  = clr_idx_q;
         port_req.data  = '0;
      end else if (wb_hit) begin
         port_req.valid = 1'b1;
         port_req.addr  = bus.wb_addr;
         port_req.data  = bus.wb_data;
      end else if (buf_q.valid) begin
         port_req = buf_q;
      end else if (ld_take) begin
         port_req.valid = 1'b1;
         port_req.addr  = bus.ld_addr;
         port_req.data  = bus.ld_data;
      end
   end

   always_comb begin
      clr_idx_d   = clr_idx_q;
      buf_d       = buf_q;
      last_addr_d = port_req.valid ? port_req.addr : last_addr_q;
      last_data_d = port_req.valid ? port_req.data : last_data_q;
      if (state_q == CLEAR) begin
         clr_idx_d = (clr_idx_q == LAST_IDX) ? AW'(1) : clr_idx_q + AW'(1);
      end else begin
         if (!wb_hit && buf_q.valid) buf_d.valid = 1'b0;
         // A younger writeback to the same register makes the buffered load stale.
         if (wb_hit && buf_q.valid && (buf_q.addr == bus.wb_addr)) buf_d.valid = 1'b0;
         if (wb_hit && ld_take) begin
            buf_d.valid = 1'b1;
            buf_d.addr  = bus.ld_addr;
            buf_d.data  = bus.ld_data;
         end
      end
   end

   assign bus.ld_ready     = ld_ready;
   assign bus.rf_writeEn   = port_req.valid;
   assign bus.rf_addressw  = port_req.addr;
   assign bus.rf_writeData = port_req.data;
   assign bus.busy         = (state_q == CLEAR);

   Hot_Bit #(.N(DEPTH), .AW(AW)) u_pending_hot (
      .idx (buf_q.addr),
      .en  (buf_q.valid),
      .hot (bus.pending_mask)
   );
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench: stimulus pushes expected register-file writes; a negedge monitor pops and compares.
module tb_regfile_write_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_write_scheduler_if #(.DEPTH(32), .BITS(64)) bus_if ();

   regfile_write_scheduler #(.DEPTH(32), .BITS(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic [4:0]  a;
      logic [63:0] d;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [63:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wv, input logic [4:0] wa, input logic [63:0] wd,
                        input logic lv, input logic [4:0] la, input logic [63:0] ld);
      bus_if.wb_valid = wv;
      bus_if.wb_addr  = wa;
      bus_if.wb_data  = wd;
      bus_if.ld_valid = lv;
      bus_if.ld_addr  = la;
      bus_if.ld_data  = ld;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && bus_if.rf_writeEn) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr=%0d data=%h expected no write at %0t",
                        bus_if.rf_addressw, bus_if.rf_writeData, $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("wr_addr", 64'(bus_if.rf_addressw), 64'(e.a));
               chk("wr_data", bus_if.rf_writeData, e.d);
            end
         end
      end
   end

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      cyc();
      cyc();
      chk("rst_busy",   64'(bus_if.busy), 64'd1);
      chk("rst_ldrdy",  64'(bus_if.ld_ready), 64'd0);
      chk("rst_pend",   64'(bus_if.pending_mask), 64'd0);
      chk("rst_wen",    64'(bus_if.rf_writeEn), 64'd1);
      chk("rst_addr",   64'(bus_if.rf_addressw), 64'd1);
      chk("rst_data",   bus_if.rf_writeData, 64'd0);

      // clear sweep, with wb traffic that must be ignored
      for (int i = 1; i < 32; i++) push(5'(i), 64'd0);
      mon_en = 1'b1;
      rst = 1'b0;
      drive(1, 5'd3, 64'hDEAD, 1, 5'd4, 64'hBEEF);
      repeat (31) cyc();
      drive(0, 0, 0, 0, 0, 0);
      chk("clr_busy",  64'(bus_if.busy), 64'd0);
      chk("clr_ldrdy", 64'(bus_if.ld_ready), 64'd1);
      chk("clr_pend",  64'(bus_if.pending_mask), 64'd0);
      cyc();

      // wb and load collide: load buffered and drained the next cycle
      drive(1, 5'd5, 64'hAA, 1, 5'd7, 64'h55);
      push(5'd5, 64'hAA);
      chk("col_ldrdy0", 64'(bus_if.ld_ready), 64'd1);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      push(5'd7, 64'h55);
      chk("col_pend1",  64'(bus_if.pending_mask), 64'h80);
      chk("col_ldrdy1", 64'(bus_if.ld_ready), 64'd0);
      cyc();
      chk("col_pend2",  64'(bus_if.pending_mask), 64'd0);
      chk("col_ldrdy2", 64'(bus_if.ld_ready), 64'd1);
      cyc();

      // buffered r9 load overtaken by a younger wb to r9
      drive(1, 5'd3, 64'h33, 1, 5'd9, 64'h11);
      push(5'd3, 64'h33);
      cyc();
      drive(1, 5'd9, 64'h22, 0, 0, 0);
      push(5'd9, 64'h22);
      chk("haz_pend1", 64'(bus_if.pending_mask), 64'h200);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      chk("haz_pend2",  64'(bus_if.pending_mask), 64'd0);
      chk("haz_ldrdy",  64'(bus_if.ld_ready), 64'd1);
      cyc();
      cyc();

      // back-to-back direct loads
      for (int i = 1; i <= 3; i++) begin
         drive(0, 0, 0, 1, 5'(i), 64'h100 + 64'(i));
         push(5'(i), 64'h100 + 64'(i));
         chk("dir_ldrdy", 64'(bus_if.ld_ready), 64'd1);
         chk("dir_pend",  64'(bus_if.pending_mask), 64'd0);
         cyc();
      end
      drive(0, 0, 0, 0, 0, 0);
      cyc();

      // r0 writes are discarded; buffered load still drains
      drive(1, 5'd4, 64'h44, 1, 5'd6, 64'h66);
      push(5'd4, 64'h44);
      cyc();
      drive(1, 5'd0, 64'hFF, 1, 5'd0, 64'h77);
      push(5'd6, 64'h66);
      chk("r0_ldrdy_full", 64'(bus_if.ld_ready), 64'd0);
      cyc();
      chk("r0_ldrdy", 64'(bus_if.ld_ready), 64'd1);
      chk("r0_wen",   64'(bus_if.rf_writeEn), 64'd0);
      chk("r0_hold_addr", 64'(bus_if.rf_addressw), 64'd6);
      chk("r0_hold_data", bus_if.rf_writeData, 64'h66);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      chk("r0_pend",   64'(bus_if.pending_mask), 64'd0);
      chk("r0_ldrdy2", 64'(bus_if.ld_ready), 64'd1);
      cyc();

      // reset while a load is buffered
      drive(1, 5'd10, 64'hA0, 1, 5'd12, 64'hC0);
      push(5'd10, 64'hA0);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      chk("mid_pend_pre", 64'(bus_if.pending_mask), 64'h1000);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_pend",  64'(bus_if.pending_mask), 64'd0);
      chk("mid_busy",  64'(bus_if.busy), 64'd1);
      chk("mid_ldrdy", 64'(bus_if.ld_ready), 64'd0);
      chk("mid_addr",  64'(bus_if.rf_addressw), 64'd1);
      chk("mid_wen",   64'(bus_if.rf_writeEn), 64'd1);
      cyc();
      for (int i = 1; i < 32; i++) push(5'(i), 64'd0);
      mon_en = 1'b1;
      rst = 1'b0;
      repeat (31) cyc();
      chk("mid_busy_end", 64'(bus_if.busy), 64'd0);
      cyc();
      cyc();

      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Controller that owns the register file's single write port (`addressw`/`writeData`/`writeEn`). After reset it sequences a clear of registers 1..DEPTH-1 to zero. In normal operation it arbitrates the port between the core writeback path (fixed priority, no backpressure) and the load-return path (valid/ready, one-entry holding buffer). It sits between the execute/memory stages and the register file, and exports a per-register pending mask for hazard stalls.

## Interface
- DEPTH, 32, number of architectural registers; register 0 is hardwired zero
- BITS, 64, data width
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; **asynchronous, active-high**
- wb_valid  in  1  core writeback request this cycle
- wb_addr  in  AW  core destination register
- wb_data  in  BITS  core write data
- ld_valid  in  1  load return valid
- ld_ready  out  1  load return accepted when ld_valid & ld_ready
- ld_addr  in  AW  load destination register
- ld_data  in  BITS  load data
- rf_addressw  out  AW  to register file write address
- rf_writeData  out  BITS  to register file write data
- rf_writeEn  out  1  to register file write enable
- busy  out  1  high while clearing; core must stall
- pending_mask  out  DEPTH  bit i set while a buffered load targets register i

## Operation
- FSM states: CLEAR, RUN.
- CLEAR:
  - Counter `clr_idx` starts at 1.
  - Each cycle drives rf_writeEn=1, rf_addressw=clr_idx, rf_writeData=0, then increments `clr_idx`.
  - After the write to DEPTH-1, goes to RUN.
  - busy=1 and ld_ready=0 throughout.
  - wb_valid is ignored.
- RUN, port selection priority:
  1. Core writeback. If wb_valid and wb_addr≠0: write wb_addr/wb_data.
  2. Buffered load. If buf_valid and the port is free: write buf_addr/buf_data and clear buf_valid.
  3. Direct load. If the port is free, buffer empty and ld accepted: write ld_addr/ld_data in the same cycle with no buffering.
  4. Otherwise rf_writeEn=0. rf_addressw and rf_writeData hold their last driven values.
- ld_ready = RUN & ~buf_valid. It depends only on registered state.
- An accepted load that cannot reach the port that cycle is captured into the buffer (buf_valid, buf_addr, buf_data).
- Writes to register 0 from either source are discarded and never occupy the port. An accepted load with ld_addr=0 is consumed but not buffered.
- Ordering hazard: if wb writes address A while buf_valid and buf_addr=A, the buffered load is dropped (buf_valid cleared). The writeback is younger and wins.
- pending_mask = one-hot(buf_addr) gated by buf_valid. All zero otherwise.

## Timing
- Reset values:
  - State CLEAR, clr_idx=1, buf_valid=0.
  - busy=1, ld_ready=0, pending_mask=0.
  - rf_writeEn=1 with rf_addressw=1, rf_writeData=0 (the first clear write happens at the first edge after rst falls).
- Clear takes exactly DEPTH-1 cycles. With DEPTH=32, busy falls after 31 rising edges from reset release.
- rf_* outputs are combinational from wb inputs, ld inputs and registered state.
  - Writeback latency: 0 (the write lands on the same edge).
  - Direct load latency: 0. Buffered load latency: at least 1.
- Load throughput: one per cycle while the core is idle. A load arriving during a writeback cycle is buffered, and ld_ready drops the next cycle.
- Reset asserted mid-operation: immediately returns to CLEAR, discards any buffered load, and restarts the clear from index 1.
- wb_valid during CLEAR is the core's responsibility (it must honour busy). The block drops such requests.

## Structure
- Package `regfile_pkg`:
  - state enum {CLEAR, RUN}
  - default DEPTH/BITS localparams
  - a write-request struct {valid, addr, data} used for both sources
- Sub-module: reuse the existing `Hot_Bit` one-hot decoder for pending_mask. Everything else stays in one module.
- The buffer is a single register set. No FIFO.

## Test plan
- Reset release, no traffic -> rf_writeEn=1 for 31 cycles, addresses 1..31 in order with data 0; then busy=0, ld_ready=1.
- RUN: wb_valid with addr 5, data 0xAA, plus a simultaneous load to addr 7, data 0x55 -> cycle 0 writes r5=0xAA; cycle 1 writes r7=0x55; pending_mask bit 7 is high during cycle 1 only; ld_ready is 0 in cycle 1.
- Buffered load to r9 (0x11), then wb to r9 (0x22) next cycle -> only r9=0x22 is written; the buffer is dropped; pending_mask returns to 0.
- Loads every cycle with no wb, addresses 1,2,3 -> direct writes with 0 latency; ld_ready stays 1; pending_mask stays 0.
- wb to r0, and a load to r0 -> rf_writeEn=0 for the wb; the load is accepted but never written; a concurrent buffered load drains in that cycle.
- Assert rst while a load is buffered in RUN -> buffer is cleared; pending_mask=0; CLEAR restarts at index 1; busy=1.
